tennis_rally_ctrl: RTL and testbench

Rally and scoring controller for the tennis game. It sits between the two debounced paddle buttons and the `tennis_ball` LED datapath. It decides when each player may strike, and it generates the one-cycle `right_trigger` / `left_trigger` pulses that launch or return the ball. It watches the 16-bit `ball` vector to detect misses, keeps the score, and declares the winner.

---
 rtl/tennis_rally_ctrl_if.sv | 27 ++
 rtl/tennis_rally_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tennis_rally_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tennis_rally_ctrl_if.sv
// Paddle/ball/score bundle between the rally controller and the board.
// master: the rally controller (takes buttons and ball, drives triggers and score).
// slave:  the environment (drives buttons and ball, watches triggers and score).
interface tennis_rally_ctrl_if;
  logic        left_btn;
  logic        right_btn;
  logic [15:0] ball;
  logic        right_trigger;
  logic        left_trigger;
  logic [3:0]  left_score;
  logic [3:0]  right_score;
  logic        point;
  logic        game_over;
  logic        winner;

  modport master (
    input  left_btn, right_btn, ball,
    output right_trigger, left_trigger, left_score, right_score,
           point, game_over, winner
  );

  modport slave (
    output left_btn, right_btn, ball,
    input  right_trigger, left_trigger, left_score, right_score,
           point, game_over, winner
  );
endinterface

// File: rtl/tennis_rally_ctrl.sv
// Rally/scoring controller: serve and return triggers, miss detection, score, winner.
// Ports: clk, reset (sync, active-high); bus (master): left_btn/right_btn/ball in,
//   right_trigger/left_trigger/left_score/right_score/point/game_over/winner out.
// Optional macro TENNIS_EARLY_FAULT_EN: hitter press on a dark end LED scores as a miss.
// Inputs are registered once, then acted on; all outputs are registered, so an
// input event sampled at edge N shows up on the outputs after edge N+1.
module tennis_rally_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned HIT_WINDOW   = 25_000_000,
  parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
  input logic               clk,
  input logic               reset,
  tennis_rally_ctrl_if.master bus
);
  typedef enum logic [2:0] {SERVE_R, SERVE_L, TO_LEFT, TO_RIGHT, PAUSE, OVER} state_t;

  localparam logic [31:0] HIT_LAST   = 32'(HIT_WINDOW - 1);
  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_CYCLES - 1);
  localparam logic [3:0]  WIN4       = 4'(WIN_SCORE);

  state_t      state, state_nxt;
  logic        btn_l_s, btn_r_s, btn_l_q, btn_r_q;
  logic [15:0] ball_s;
  logic [31:0] win_cnt, win_cnt_nxt, pause_cnt, pause_cnt_nxt;
  logic        serve_right, serve_right_nxt;
  logic        rtrig, rtrig_nxt, ltrig, ltrig_nxt, pt, pt_nxt;
  logic        go, go_nxt, win, win_nxt;
  logic [3:0]  ls, ls_nxt, rs, rs_nxt, new_score;
  logic        press_l, press_r, early_l, early_r, miss, scorer_right;

  // Rising edge of the sampled button level only.
  assign press_l = btn_l_s & ~btn_l_q;
  assign press_r = btn_r_s & ~btn_r_q;

`ifdef TENNIS_EARLY_FAULT_EN
  assign early_l = press_l & ~ball_s[15];
  assign early_r = press_r & ~ball_s[0];
`else
  assign early_l = 1'b0;
  assign early_r = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    win_cnt_nxt     = win_cnt;
    pause_cnt_nxt   = pause_cnt;
    serve_right_nxt = serve_right;
    rtrig_nxt       = 1'b0;
    ltrig_nxt       = 1'b0;
    pt_nxt          = 1'b0;
    ls_nxt          = ls;
    rs_nxt          = rs;
    go_nxt          = go;
    win_nxt         = win;
    miss            = 1'b0;
    scorer_right    = 1'b0;
    new_score       = 4'd0;
    case (state)
      SERVE_R: if (press_r) begin
        rtrig_nxt   = 1'b1;
        state_nxt   = TO_LEFT;
        win_cnt_nxt = 32'd0;
      end
      SERVE_L: if (press_l) begin
        ltrig_nxt   = 1'b1;
        state_nxt   = TO_RIGHT;
        win_cnt_nxt = 32'd0;
      end
      TO_LEFT: begin
        win_cnt_nxt = ball_s[15] ? win_cnt + 32'd1 : 32'd0;
        // Hit is checked first so it beats a miss in the same cycle.
        // win_cnt holds the lit cycles before this one, hence HIT_WINDOW-1.
        if (press_l && ball_s[15]) begin
          ltrig_nxt   = 1'b1;
          state_nxt   = TO_RIGHT;
          win_cnt_nxt = 32'd0;
        end else if ((ball_s[15] && win_cnt >= HIT_LAST) || ball_s == 16'h0000 || early_l) begin
          miss         = 1'b1;
          scorer_right = 1'b1;
        end
      end
      TO_RIGHT: begin
        win_cnt_nxt = ball_s[0] ? win_cnt + 32'd1 : 32'd0;
        if (press_r && ball_s[0]) begin
          rtrig_nxt   = 1'b1;
          state_nxt   = TO_LEFT;
          win_cnt_nxt = 32'd0;
        end else if ((ball_s[0] && win_cnt >= HIT_LAST) || ball_s == 16'h0000 || early_r) begin
          miss         = 1'b1;
          scorer_right = 1'b0;
        end
      end
      PAUSE: begin
        if (pause_cnt == PAUSE_LAST) begin
          state_nxt     = serve_right ? SERVE_R : SERVE_L;
          pause_cnt_nxt = 32'd0;
        end else begin
          pause_cnt_nxt = pause_cnt + 32'd1;
        end
      end
      default: ;  // OVER: frozen until reset
    endcase

    if (miss) begin
      pt_nxt    = 1'b1;
      new_score = scorer_right ? rs + 4'd1 : ls + 4'd1;
      if (scorer_right) rs_nxt = new_score;
      else              ls_nxt = new_score;
      if (new_score == WIN4) begin
        state_nxt = OVER;
        go_nxt    = 1'b1;
        win_nxt   = scorer_right;
      end else begin
        state_nxt       = PAUSE;
        serve_right_nxt = scorer_right;
        pause_cnt_nxt   = 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SERVE_R;
      btn_l_s     <= 1'b0;
      btn_r_s     <= 1'b0;
      btn_l_q     <= 1'b0;
      btn_r_q     <= 1'b0;
      ball_s      <= 16'h0000;
      win_cnt     <= 32'd0;
      pause_cnt   <= 32'd0;
      serve_right <= 1'b0;
      rtrig       <= 1'b0;
      ltrig       <= 1'b0;
      pt          <= 1'b0;
      ls          <= 4'd0;
      rs          <= 4'd0;
      go          <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_nxt;
      btn_l_s     <= bus.left_btn;
      btn_r_s     <= bus.right_btn;
      btn_l_q     <= btn_l_s;
      btn_r_q     <= btn_r_s;
      ball_s      <= bus.ball;
      win_cnt     <= win_cnt_nxt;
      pause_cnt   <= pause_cnt_nxt;
      serve_right <= serve_right_nxt;
      rtrig       <= rtrig_nxt;
      ltrig       <= ltrig_nxt;
      pt          <= pt_nxt;
      ls          <= ls_nxt;
      rs          <= rs_nxt;
      go          <= go_nxt;
      win         <= win_nxt;
    end
  end

  assign bus.right_trigger = rtrig;
  assign bus.left_trigger  = ltrig;
  assign bus.left_score    = ls;
  assign bus.right_score   = rs;
  assign bus.point         = pt;
  assign bus.game_over     = go;
  assign bus.winner        = win;
endmodule

// File: tb/tb_tennis_rally_ctrl.sv
// Testbench for tennis_rally_ctrl: directed rally scenarios, then random play,
// every cycle compared against an event/timestamp-level model of the game rules.
module tb_tennis_rally_ctrl;
  localparam int HW  = 4;
  localparam int PC  = 8;
  localparam int WIN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tennis_rally_ctrl_if bus();

  tennis_rally_ctrl #(.WIN_SCORE(WIN), .HIT_WINDOW(HW), .PAUSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef enum {PH_SERVE, PH_RALLY, PH_PAUSE, PH_OVER} phase_e;
  phase_e      m_phase = PH_SERVE;
  bit          m_side  = 1'b1;  // server in PH_SERVE, hitter in PH_RALLY, next server in PH_PAUSE
  int          m_cyc = 0, m_lit_since = 0, m_open_at = 0;
  bit          m_was_lit = 0;
  bit          s_lb = 0, s_rb = 0, q_lb = 0, q_rb = 0;
  logic [15:0] s_ball = 16'h0;
  bit          e_rt = 0, e_lt = 0, e_pt = 0, e_go = 0, e_win = 0;
  int          e_ls = 0, e_rs = 0;

  task automatic award(input bit w);
    if (w) e_rs++; else e_ls++;
    e_pt = 1;
    if ((w ? e_rs : e_ls) == WIN) begin
      m_phase = PH_OVER; e_go = 1; e_win = w;
    end else begin
      m_phase = PH_PAUSE; m_side = w; m_open_at = m_cyc + PC;
    end
  endtask

  task automatic model_edge(input bit r, input bit lb, input bit rb, input logic [15:0] b);
    bit pl, pr, hp, lit, early;
    m_cyc++;
    if (r) begin
      m_phase = PH_SERVE; m_side = 1; m_was_lit = 0;
      s_lb = 0; s_rb = 0; q_lb = 0; q_rb = 0; s_ball = 16'h0;
      e_rt = 0; e_lt = 0; e_pt = 0; e_go = 0; e_win = 0; e_ls = 0; e_rs = 0;
      return;
    end
    e_rt = 0; e_lt = 0; e_pt = 0;
    pl = s_lb && !q_lb;
    pr = s_rb && !q_rb;
    case (m_phase)
      PH_SERVE: begin
        if (m_side && pr) begin
          e_rt = 1; m_phase = PH_RALLY; m_side = 0; m_was_lit = 0;
        end else if (!m_side && pl) begin
          e_lt = 1; m_phase = PH_RALLY; m_side = 1; m_was_lit = 0;
        end
      end
      PH_RALLY: begin
        hp  = m_side ? pr : pl;
        lit = m_side ? s_ball[0] : s_ball[15];
        if (lit) begin
          if (!m_was_lit) m_lit_since = m_cyc;
          m_was_lit = 1;
        end else m_was_lit = 0;
`ifdef TENNIS_EARLY_FAULT_EN
        early = hp && !lit;
`else
        early = 0;
`endif
        if (hp && lit) begin
          if (m_side) e_rt = 1; else e_lt = 1;
          m_side = !m_side; m_was_lit = 0;
        end else if ((lit && (m_cyc - m_lit_since + 1) >= HW) || s_ball == 16'h0 || early)
          award(!m_side);
      end
      PH_PAUSE: if (m_cyc >= m_open_at) m_phase = PH_SERVE;
      default: ;
    endcase
    q_lb = s_lb; q_rb = s_rb;
    s_lb = lb;   s_rb = rb; s_ball = b;
  endtask

  // One clock edge with the given inputs, then compare every output to the model.
  task automatic step(input bit r, input bit lb, input bit rb, input logic [15:0] b);
    @(negedge clk);
    reset = r; bus.left_btn = lb; bus.right_btn = rb; bus.ball = b;
    @(posedge clk);
    model_edge(r, lb, rb, b);
    #1;
    check("right_trigger", 32'(bus.right_trigger), 32'(e_rt));
    check("left_trigger",  32'(bus.left_trigger),  32'(e_lt));
    check("left_score",    32'(bus.left_score),    32'(e_ls));
    check("right_score",   32'(bus.right_score),   32'(e_rs));
    check("point",         32'(bus.point),         32'(e_pt));
    check("game_over",     32'(bus.game_over),     32'(e_go));
    check("winner",        32'(bus.winner),        32'(e_win));
    check("trig_excl",     32'(bus.right_trigger & bus.left_trigger), 32'd0);
  endtask

  // Right serves after the pause and the left side is charged an off-court miss.
  task automatic right_point();
    repeat (10) step(0, 0, 0, 16'h0100);
    step(0, 0, 1, 16'h0100);
    step(0, 0, 1, 16'h0100);
    check("rp_serve", 32'(bus.right_trigger), 32'd1);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    check("rp_point", 32'(bus.point), 32'd1);
  endtask

  bit          lb, rb, rr;
  logic [15:0] rball;

  initial begin
    bus.left_btn = 0; bus.right_btn = 0; bus.ball = 16'h0001;

    // 1: reset and right serve
    step(1, 0, 0, 16'h0001);
    step(1, 0, 0, 16'h0001);
    check("rst_scores", 32'({bus.left_score, bus.right_score}), 32'd0);
    check("rst_go", 32'(bus.game_over), 32'd0);
    step(0, 0, 1, 16'h0001);
    check("serve_early", 32'(bus.right_trigger), 32'd0);
    step(0, 0, 1, 16'h0001);
    check("serve_trig", 32'(bus.right_trigger), 32'd1);
    step(0, 0, 1, 16'h0001);
    check("serve_once", 32'(bus.right_trigger), 32'd0);

    // 2: left return
    step(0, 1, 0, 16'h8000);
    step(0, 1, 0, 16'h8000);
    check("return_lt", 32'(bus.left_trigger), 32'd1);
    check("return_pt", 32'(bus.point), 32'd0);

    // 3: window miss on the right end, then pause and left serve
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 16'h0001);
      check("window_wait", 32'(bus.point), 32'd0);
    end
    step(0, 0, 0, 16'h0001);
    check("window_pt", 32'(bus.point), 32'd1);
    check("window_ls", 32'(bus.left_score), 32'd1);
    repeat (6) step(0, 0, 0, 16'h0100);
    step(0, 1, 0, 16'h0100);
    step(0, 1, 0, 16'h0100);
    check("pause_last_press", 32'(bus.left_trigger), 32'd0);
    step(0, 1, 0, 16'h0100);
    step(0, 0, 0, 16'h0100);
    step(0, 1, 0, 16'h0100);
    step(0, 1, 0, 16'h0100);
    check("serve_l", 32'(bus.left_trigger), 32'd1);

    // 4: right return, simultaneous press, off-court
    step(0, 0, 1, 16'h0001);
    step(0, 0, 1, 16'h0001);
    check("ret_rt", 32'(bus.right_trigger), 32'd1);
    step(0, 0, 0, 16'h0100);
    step(0, 1, 1, 16'h8000);
    step(0, 1, 1, 16'h8000);
    check("both_lt", 32'(bus.left_trigger), 32'd1);
    check("both_rt", 32'(bus.right_trigger), 32'd0);
    step(0, 0, 0, 16'h0001);
    step(0, 0, 1, 16'h0001);
    step(0, 0, 1, 16'h0001);
    check("ret2_rt", 32'(bus.right_trigger), 32'd1);
    step(0, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000);
    check("offcourt_rs", 32'(bus.right_score), 32'd1);
    check("offcourt_pt", 32'(bus.point), 32'd1);

    // 5: right reaches WIN_SCORE
    right_point();
    right_point();
    check("over_go", 32'(bus.game_over), 32'd1);
    check("over_win", 32'(bus.winner), 32'd1);
    check("over_scores", 32'({bus.left_score, bus.right_score}), 32'h13);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 16'h8000);
      step(0, 0, 0, 16'h0001);
      check("over_frozen", 32'({bus.left_trigger, bus.right_trigger, bus.right_score}), 32'd3);
    end
    step(1, 0, 0, 16'h0100);
    check("rst_after_over", 32'({bus.game_over, bus.winner, bus.left_score, bus.right_score}), 32'd0);

    // 6: early left press with ball mid-court
    step(0, 0, 1, 16'h0100);
    step(0, 0, 1, 16'h0100);
    check("early_serve", 32'(bus.right_trigger), 32'd1);
    step(0, 0, 0, 16'h0100);
    step(0, 1, 0, 16'h0100);
    step(0, 1, 0, 16'h0100);
`ifdef TENNIS_EARLY_FAULT_EN
    check("early_pt", 32'(bus.point), 32'd1);
    check("early_rs", 32'(bus.right_score), 32'd1);
`else
    check("early_pt", 32'(bus.point), 32'd0);
    check("early_rs", 32'(bus.right_score), 32'd0);
`endif

    // random play
    lb = 0; rb = 0; rball = 16'h0100;
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(0, 199) == 0) || (e_go && $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) lb = !lb;
      if ($urandom_range(0, 3) == 0) rb = !rb;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0:       rball = 16'h0000;
          1, 2, 3: rball = 16'h8000;
          4, 5, 6: rball = 16'h0001;
          default: rball = 16'(1 << $urandom_range(1, 14));
        endcase
      end
      step(rr, lb, rb, rball);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
